// File: rtl/saida_display_io_pkg.sv
// Shared definitions for the processor IO blocks:
// FSM state encoding and active-low 7-segment patterns.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_pattern(input logic [3:0] d);
        logic [6:0] p;
        p = SEG_BLANK;
        unique case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/saida_display_io_if.sv
// Processor OUT port bundle: write strobe and data in,
// busy/done handshake and the segment drive back out.
interface saida_display_io_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
);
    logic                  out_en;
    logic [DATA_W-1:0]     out_data;
    logic                  busy;
    logic                  done;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output out_en, out_data,
        input  busy, done, seg
    );

    modport slave (
        input  out_en, out_data,
        output busy, done, seg
    );
endinterface

// File: rtl/saida_display_io_bcd_to_seg7.sv
// One 7-segment digit: BCD nibble to active-low pattern,
// forced dark when the blank flag is set.
module bcd_to_seg7
    import io_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup with blank override
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg7_pattern(digit);
        end
    end

endmodule

// File: rtl/saida_display_io.sv
// Processor output port: latches a word, converts it to BCD
// by shift-add-3 and drives blanked 7-segment displays.
module saida_display_io
    import io_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    saida_display_io_if.slave bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] bin;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_shl;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     disp_digits;
    logic              disp_valid;
    logic [DIGITS-1:0] blank;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state: one load, DATA_W shifts, one update cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.out_en) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add 3 to every nibble >= 5, then shift in the next bin bit
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
        bcd_shl = {bcd_adj[BW-2:0], bin[DATA_W-1]};
    end

    // Conversion datapath and display latch; the display is
    // loaded on the last shift so UPDATE already shows it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            disp_digits <= '0;
            disp_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.out_en) begin
                        bin <= bus.out_data;
                        bcd <= '0;
                        cnt <= CW'(DATA_W);
                    end
                end
                SHIFT: begin
                    bcd <= bcd_shl;
                    bin <= {bin[DATA_W-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        disp_digits <= bcd_shl;
                        disp_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blank chain, walking down from the top digit
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_digits[4*i +: 4] == 4'd0);
            blank[i]   = !disp_valid || ((i > 0) && zero_above);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_to_seg7 u_seg (
            .digit (disp_digits[4*g +: 4]),
            .blank (blank[g]),
            .seg   (bus.seg[7*g +: 7])
        );
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == UPDATE);

endmodule

// File: doc/saida_display_io.md
# saida_display_io

Processor-to-user output port: the write-side counterpart of the switch input filter. A single-cycle OUT strobe from the processor latches an unsigned word. The block converts it to BCD with a sequential shift-add-3 (double-dabble) engine and drives the board's active-low 7-segment displays with leading-zero blanking. `busy` stalls the processor while a conversion is in flight; the previously shown value stays on the displays until the new one is ready.

## Interface
- `DATA_W`, default 16: width of the processor output word, unsigned.
- `DIGITS`, default 5: number of 7-segment digits; must satisfy 10^DIGITS > 2^DATA_W - 1.
- `clk`, in, 1: single system clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `out_en`, in, 1: one-cycle write strobe from the OUT instruction.
- `out_data`, in, DATA_W: value to display; sampled only with `out_en` in IDLE.
- `busy`, out, 1: conversion in progress; the processor holds further OUT writes while high.
- `done`, out, 1: one-cycle pulse; the new value is on the displays this cycle.
- `seg`, out, 7*DIGITS: active-low segments.
  - Digit i occupies `seg[7*i+6:7*i]`, bit order {g,f,e,d,c,b,a}.
  - Digit 0 is the units digit.

## Operation
- FSM states are IDLE, SHIFT and UPDATE.
- **IDLE:** on `out_en`=1:
  - bin ← `out_data`
  - bcd ← 0
  - cnt ← DATA_W
  - go to SHIFT
- **SHIFT:** each cycle:
  - Every 4-bit BCD nibble ≥ 5 gets +3.
  - Then {bcd, bin} shifts left by 1 and cnt decrements.
  - When cnt reaches 1 at the edge (last shift), go to UPDATE.
  - Exactly DATA_W shift cycles.
- **UPDATE:**
  - disp_digits ← bcd
  - disp_valid ← 1
  - `done` = 1
  - go to IDLE
- `busy` = (state != IDLE), registered with the state.
- `out_en` outside IDLE is ignored: no queueing, no effect on the conversion in flight.
- Display decode is combinational from disp_digits/disp_valid:
  - disp_valid=0: all digits blank (7'h7F).
  - Leading-zero blanking: digit i>0 is blank if it and every higher digit are 0.
  - Digit 0 is always shown.
- BCD nibble width is 4*DIGITS. Add-3 is applied per nibble with no carry between nibbles; the final value always fits.
- Patterns (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - blank=7F
- **Reset (asynchronous, any state):**
  - state=IDLE, `busy`=0, `done`=0
  - disp_valid=0, so `seg` is all ones
  - bin, bcd, cnt = 0
- Reset mid-conversion aborts without a `done` pulse.

## Timing
- `out_en` is sampled at edge k. `busy`=1 from edge k through edge k+DATA_W+1.
- SHIFT occupies edges k+1 … k+DATA_W. At edge k+DATA_W+1, UPDATE is left:
  - `done`=1 for the cycle after edge k+DATA_W (the UPDATE state).
  - `seg` shows the new value in that same cycle.
  - `busy` drops at edge k+DATA_W+1.
- Total busy time is DATA_W+1 cycles (17 at default).
- A new `out_en` is accepted from the first IDLE cycle, so back-to-back writes are spaced ≥ DATA_W+2 cycles apart.
- `seg` is stable (old value) for the whole conversion.
- No combinational path from `out_en` to `busy`.

## Structure
- **Shared package `io_pkg`:**
  - FSM state encoding (IDLE/SHIFT/UPDATE)
  - 7-segment pattern constants (digits 0–9, SEG_BLANK=7'h7F)
  - Also used by other IO blocks.
- **Sub-module `bcd_to_seg7`:**
  - Ports: 4-bit digit, blank flag → 7-bit active-low pattern.
  - Instantiated DIGITS times via generate.
- The top level holds the FSM, the shift-add-3 datapath and the leading-zero blank chain.

## Test plan
- **Reset:** hold `reset_n`=0 → `seg`=all ones (35'h7FFFFFFFF), `busy`=0, `done`=0. Release; outputs unchanged without `out_en`.
- **Value 12345:** `out_en` with 16'd12345 → `busy` high 17 cycles; `done` one cycle at cycle 17. Digits 4..0 = 79,24,30,19,12.
- **Value 0:** `out_data`=16'd0 → digit 0 = 7'h40; digits 1–4 = 7'h7F.
- **Value 65535 / 9:** 16'd65535 → digits 6,5,5,3,5, all lit. Then 16'd9 → digit 0 = 7'h10, others blank.
- **Write while busy:** `out_en` with 16'd42, then `out_en` with 16'd777 at cycle 5 → ignored. `done` once; display shows 42 (digits 1,0 = 19,24). `seg` keeps the prior value until `done`.
- **Reset mid-conversion:** `reset_n` low at cycle 8 of a conversion → `busy`=0 and `seg` blank immediately (async); no `done`. After release, `out_en` with 16'd7 → digit 0 = 7'h78 after 17 cycles.
